floatingpoint_multiplier: RTL and testbench
===========================================

# floatingpoint_multiplier

Sequential single-precision floating-point multiplier, the multiplicative counterpart of the team's floating-point divider. It takes the same split-field operands (sign, biased 8-bit exponent, 24-bit fraction with explicit hidden bit) and returns the product in the same split-field form. It uses a radix-2 shift-add mantissa datapath with a start/done handshake, and sits beside the divider in the arithmetic unit.

## Interface
- No parameters; all widths are fixed.
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only when the block is not busy
- s1, s2  input  1  operand signs
- e1, e2  input  8  operand biased exponents (bias 127)
- f1, f2  input  24  operand fractions; bit 23 is the explicit hidden bit
- s3  output  1  product sign
- e3  output  8  product biased exponent
- f3  output  24  product fraction; bit 23 is the hidden bit
- busy_o  output  1  high while a multiply is in progress
- done_o  output  1  one-cycle pulse; s3/e3/f3/ovf_o/unf_o are valid from this cycle
- ovf_o  output  1  exponent overflow on the last result
- unf_o  output  1  exponent underflow on the last result

## Operation
- States: IDLE, MUL, NORM, DONE.
- IDLE or DONE with start_i=1:
  - Latch f1 into the multiplicand register and f2 into the multiplier register.
  - Latch s1^s2 and the 10-bit signed sum e1+e2-127.
  - Clear the 48-bit accumulator and the 5-bit counter; go to MUL.
- IDLE or DONE with start_i=0: DONE goes to IDLE; IDLE stays.
- MUL, one iteration per cycle:
  - If multiplier bit 0 = 1, add multiplicand<<count to the accumulator.
  - Shift the multiplier right by one; increment the counter.
  - After the 24th iteration (counter = 23), go to NORM.
- start_i is ignored in MUL and NORM. Operand inputs may change freely after the start cycle.
- NORM normalizes the 48-bit product P and registers the outputs, then goes to DONE:
  - P[47]=1: f3 = P[47:24], exp = sum+1.
  - Otherwise: f3 = P[46:23], exp = sum.
  - Rounding is by truncation only.
- Special cases, resolved in NORM with priority zero > overflow > underflow:
  - Zero: f1==0 or f2==0 gives e3=0, f3=0, ovf_o=0, unf_o=0. s3 still equals s1^s2.
  - Overflow: exp > 254 gives ovf_o=1, e3=255, f3=0.
  - Underflow: exp < 1 gives unf_o=1, e3=0, f3=0.
  - Otherwise: e3 = exp[7:0], ovf_o=0, unf_o=0.
- Outputs hold their values until the next NORM or reset.
- No NaN/Inf input decoding; exponent 255 on an input is treated arithmetically.

## Timing
- Reset values (also applied when reset occurs mid-operation): state IDLE; s3=0, e3=0, f3=0, busy_o=0, done_o=0, ovf_o=0, unf_o=0; accumulator and counter cleared. The in-flight operation is discarded.
- Reset has priority over start_i on the same edge.
- Latency, for start sampled at edge N:
  - busy_o is high from edge N to edge N+25 (MUL and NORM).
  - Outputs update at edge N+25.
  - done_o is high for exactly the cycle between edges N+25 and N+26.
- Latency is constant at 25 cycles regardless of operand values, including zero operands.
- Back-to-back: start_i=1 during the DONE cycle is accepted at edge N+26, so the throughput is one result per 26 cycles.

## Test plan
- Normal, no renormalization: s1=0, e1=127, f1=0xC00000 (1.5) × s2=0, e2=128, f2=0x800000 (2.0) → after 25 cycles done_o=1, s3=0, e3=128, f3=0xC00000 (3.0), ovf_o=0, unf_o=0.
- Renormalization and sign: 1.5 × -1.5 (s2=1, e2=127, f2=0xC00000) → s3=1, e3=128, f3=0x900000 (-2.25).
- Overflow and underflow:
  - e1=e2=200, f1=f2=0x800000 → ovf_o=1, e3=255, f3=0.
  - Next, e1=e2=50 → unf_o=1, ovf_o=0, e3=0, f3=0.
- Zero and busy-ignore: f1=0, e1=130, with start_i pulsed again at cycle 10 → exactly one done_o at cycle 25, e3=0, f3=0, busy_o stays high throughout.
- Reset mid-operation: assert rst_i at cycle 12 → next cycle all outputs 0, busy_o=0. A fresh start of 1.0 × 1.0 → e3=127, f3=0x800000 at cycle 25.
- Back-to-back: a second start during the DONE cycle → second done_o exactly 26 cycles after the first, with the first result held until then.

Source files
------------

// File: rtl/floatingpoint_multiplier.sv
// Sequential single-precision multiplier on split-field operands (sign, biased exponent,
// 24-bit fraction with explicit hidden bit). Radix-2 shift-add, 25-cycle latency, truncation.
//
// state | meaning
// IDLE  | waiting for start_i
// MUL   | one shift-add iteration per cycle, 24 iterations
// NORM  | normalize product, resolve zero/overflow/underflow, register outputs
// DONE  | results valid, done_o high; start_i accepted here for back-to-back issue
module floatingpoint_multiplier (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        s1,
  input  logic        s2,
  input  logic [7:0]  e1,
  input  logic [7:0]  e2,
  input  logic [23:0] f1,
  input  logic [23:0] f2,
  output logic        s3,
  output logic [7:0]  e3,
  output logic [23:0] f3,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic        unf_o
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [23:0]        mcand_q;
  logic [23:0]        mplier_q;
  logic [47:0]        acc_q;
  logic [4:0]         cnt_q;
  logic               sign_q;
  logic signed [9:0]  esum_q;
  logic               accept;
  logic [47:0]        addend;
  logic signed [9:0]  exp_n;
  logic [23:0]        frac_n;
  logic [7:0]         e_n;
  logic [23:0]        f_n;
  logic               ovf_n;
  logic               unf_n;

  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign busy_o = (state_q == MUL) || (state_q == NORM);
  assign done_o = (state_q == DONE);
  assign addend = {24'd0, mcand_q} << cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = MUL;
      MUL:  if (cnt_q == 5'd23) state_d = NORM;
      NORM: state_d = DONE;
      DONE: state_d = start_i ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero accumulator can only come from a zero operand, so it doubles as the zero test.
  always_comb begin
    exp_n  = acc_q[47] ? esum_q + 10'sd1 : esum_q;
    frac_n = acc_q[47] ? acc_q[47:24] : acc_q[46:23];
    e_n    = exp_n[7:0];
    f_n    = frac_n;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    if (acc_q == 48'd0) begin
      e_n = 8'd0;
      f_n = 24'd0;
    end else if (exp_n > 10'sd254) begin
      e_n   = 8'hFF;
      f_n   = 24'd0;
      ovf_n = 1'b1;
    end else if (exp_n < 10'sd1) begin
      e_n   = 8'd0;
      f_n   = 24'd0;
      unf_n = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      esum_q   <= '0;
      s3       <= 1'b0;
      e3       <= '0;
      f3       <= '0;
      ovf_o    <= 1'b0;
      unf_o    <= 1'b0;
    end else if (accept) begin
      mcand_q  <= f1;
      mplier_q <= f2;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= s1 ^ s2;
      esum_q   <= $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
    end else if (state_q == MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + addend;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
    end else if (state_q == NORM) begin
      s3    <= sign_q;
      e3    <= e_n;
      f3    <= f_n;
      ovf_o <= ovf_n;
      unf_o <= unf_n;
    end
  end

endmodule

// File: tb/tb_floatingpoint_multiplier.sv
// Bench for floatingpoint_multiplier: directed cases plus random operands checked against
// an integer-arithmetic reference of the product, with latency and handshake checks.
module tb_floatingpoint_multiplier;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        s1 = 1'b0, s2 = 1'b0;
  logic [7:0]  e1 = '0, e2 = '0;
  logic [23:0] f1 = '0, f2 = '0;
  logic        s3, busy_o, done_o, ovf_o, unf_o;
  logic [7:0]  e3;
  logic [23:0] f3;

  int n_checks = 0;
  int n_fail   = 0;

  floatingpoint_multiplier dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .s1(s1), .s2(s2), .e1(e1), .e2(e2), .f1(f1), .f2(f2),
    .s3(s3), .e3(e3), .f3(f3),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
    $fatal(1, "watchdog");
  end

  // Packed result: {s, e[7:0], f[23:0], ovf, unf}
  function automatic logic [34:0] model(input logic a_s, input logic b_s,
                                        input logic [7:0] a_e, input logic [7:0] b_e,
                                        input logic [23:0] a_f, input logic [23:0] b_f);
    longint prod;
    int     ex;
    logic [23:0] fr;
    logic   sg;
    prod = longint'(a_f) * longint'(b_f);
    ex   = int'(a_e) + int'(b_e) - 127;
    sg   = a_s ^ b_s;
    if (prod >= (longint'(1) << 47)) begin
      fr = 24'(prod / (longint'(1) << 24));
      ex = ex + 1;
    end else begin
      fr = 24'((prod / (longint'(1) << 23)) % (longint'(1) << 24));
    end
    if (prod == 0)     return {sg, 8'd0, 24'd0, 1'b0, 1'b0};
    else if (ex > 254) return {sg, 8'd255, 24'd0, 1'b1, 1'b0};
    else if (ex < 1)   return {sg, 8'd0, 24'd0, 1'b0, 1'b1};
    else               return {sg, 8'(ex), fr, 1'b0, 1'b0};
  endfunction

  function automatic logic [34:0] got();
    return {s3, e3, f3, ovf_o, unf_o};
  endfunction

  // Presents operands for one cycle with start_i, then scrambles them; returns at the
  // falling edge right after the start edge.
  task automatic issue(input logic a_s, input logic b_s, input logic [7:0] a_e,
                       input logic [7:0] b_e, input logic [23:0] a_f, input logic [23:0] b_f);
    @(negedge clk_i);
    s1 = a_s; s2 = b_s; e1 = a_e; e2 = b_e; f1 = a_f; f2 = b_f;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    s1 = 1'($urandom); e1 = 8'($urandom); f1 = 24'($urandom);
    s2 = 1'($urandom); e2 = 8'($urandom); f2 = 24'($urandom);
  endtask

  // Counts falling edges until done_o; pulses start_i once at pulse_at if non-negative.
  task automatic wait_done(input int pulse_at, output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 40 && !done_o) begin
      if (!busy_o) busy_ok = 1'b0;
      start_i = (cyc == pulse_at);
      e1 = 8'($urandom); f1 = 24'($urandom);
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({got(), busy_o, done_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h busy=%b done=%b, want all zero", got(), busy_o, done_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic run_directed(input string name, input logic a_s, input logic b_s,
                              input logic [7:0] a_e, input logic [7:0] b_e,
                              input logic [23:0] a_f, input logic [23:0] b_f,
                              input logic [34:0] want);
    int cyc;
    bit bok;
    issue(a_s, b_s, a_e, b_e, a_f, b_f);
    wait_done(-1, cyc, bok);
    n_checks++;
    if (cyc !== 25 || !bok) begin
      n_fail++;
      $display("FAIL %s_latency: done after %0d cycles busy_ok=%0d, want 25 and 1", name, cyc, bok);
    end
    n_checks++;
    if (got() !== want) begin
      n_fail++;
      $display("FAIL %s_result: got %h, want %h", name, got(), want);
    end
  endtask

  task automatic test_directed();
    run_directed("normal",   0, 0, 8'd127, 8'd128, 24'hC00000, 24'h800000,
                 {1'b0, 8'd128, 24'hC00000, 2'b00});
    run_directed("renorm",   0, 1, 8'd127, 8'd127, 24'hC00000, 24'hC00000,
                 {1'b1, 8'd128, 24'h900000, 2'b00});
    run_directed("overflow", 0, 0, 8'd200, 8'd200, 24'h800000, 24'h800000,
                 {1'b0, 8'd255, 24'd0, 2'b10});
    run_directed("underflow", 0, 0, 8'd50, 8'd50, 24'h800000, 24'h800000,
                 {1'b0, 8'd0, 24'd0, 2'b01});
    run_directed("exp254",   1, 1, 8'd127, 8'd254, 24'h800000, 24'h800000,
                 {1'b0, 8'd254, 24'h800000, 2'b00});
    run_directed("exp1",     1, 0, 8'd1, 8'd127, 24'h800000, 24'h800000,
                 {1'b1, 8'd1, 24'h800000, 2'b00});
  endtask

  task automatic test_zero_busy_ignore();
    int cyc;
    bit bok;
    int extra;
    issue(1, 0, 8'd130, 8'd100, 24'd0, 24'hA00000);
    wait_done(10, cyc, bok);
    n_checks++;
    if (cyc !== 25 || !bok) begin
      n_fail++;
      $display("FAIL zero_latency: done after %0d cycles busy_ok=%0d, want 25 and 1", cyc, bok);
    end
    n_checks++;
    if (got() !== {1'b1, 8'd0, 24'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL zero_result: got %h, want %h", got(), {1'b1, 8'd0, 24'd0, 2'b00});
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL zero_single_done: %0d extra busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit bok;
    issue(0, 0, 8'd127, 8'd127, 24'hC00000, 24'hC00000);
    repeat (11) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++;
    if ({got(), busy_o, done_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h busy=%b done=%b, want all zero", got(), busy_o, done_o);
    end
    repeat (30) @(negedge clk_i);
    n_checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_discard: busy=%b done=%b, want 00", busy_o, done_o);
    end
    run_directed("after_reset", 0, 0, 8'd127, 8'd127, 24'h800000, 24'h800000,
                 {1'b0, 8'd127, 24'h800000, 2'b00});
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bok;
    bit held;
    logic [34:0] want_a, want_b;
    want_a = model(0, 1, 8'd130, 8'd120, 24'hF00001, 24'hABCDEF);
    want_b = model(1, 1, 8'd90, 8'd60, 24'h812345, 24'hFFFFFF);
    issue(0, 1, 8'd130, 8'd120, 24'hF00001, 24'hABCDEF);
    wait_done(-1, cyc, bok);
    n_checks++;
    if (cyc !== 25 || got() !== want_a) begin
      n_fail++;
      $display("FAIL b2b_first: cycles %0d result %h, want 25 and %h", cyc, got(), want_a);
    end
    s1 = 1; s2 = 1; e1 = 8'd90; e2 = 8'd60; f1 = 24'h812345; f2 = 24'hFFFFFF;
    start_i = 1'b1;
    cyc = 0;
    held = 1'b1;
    do begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) begin
        start_i = 1'b0;
        e1 = 8'($urandom); f1 = 24'($urandom); f2 = 24'($urandom);
      end
      if (!done_o && got() !== want_a) held = 1'b0;
    end while (!done_o && cyc < 40);
    n_checks++;
    if (cyc !== 26 || !held) begin
      n_fail++;
      $display("FAIL b2b_spacing: second done %0d cycles after first, held=%0d, want 26 and 1",
               cyc, held);
    end
    n_checks++;
    if (got() !== want_b) begin
      n_fail++;
      $display("FAIL b2b_second: got %h, want %h", got(), want_b);
    end
  endtask

  task automatic test_random();
    int cyc;
    bit bok;
    logic a_s, b_s;
    logic [7:0] a_e, b_e;
    logic [23:0] a_f, b_f;
    logic [34:0] want;
    for (int i = 0; i < 24; i++) begin
      a_s = 1'($urandom); b_s = 1'($urandom);
      a_e = 8'($urandom); b_e = 8'($urandom);
      if (i % 3 == 0) begin
        a_e = 8'($urandom_range(100, 160));
        b_e = 8'($urandom_range(100, 160));
      end
      a_f = {1'b1, 23'($urandom)};
      b_f = {1'b1, 23'($urandom)};
      if ($urandom_range(0, 7) == 0) a_f = 24'd0;
      if ($urandom_range(0, 7) == 0) b_f = 24'($urandom);
      want = model(a_s, b_s, a_e, b_e, a_f, b_f);
      issue(a_s, b_s, a_e, b_e, a_f, b_f);
      wait_done(-1, cyc, bok);
      n_checks++;
      if (cyc !== 25 || !bok || got() !== want) begin
        n_fail++;
        $display("FAIL random_%0d: ops %b/%h/%h x %b/%h/%h cycles %0d busy_ok %0d got %h want %h",
                 i, a_s, a_e, a_f, b_s, b_e, b_f, cyc, bok, got(), want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
